// File: rtl/satagtx_rst_seq.sv
// satagtx_rst_seq: reset and lock sequencer for 1-4 SATA GTX/GTP channels
// sharing one transceiver tile. It pulses the tile PLL reset and then the
// user-clock DCM/PLL reset. Next it releases the per-channel TX/RX resets
// and reports per-channel readiness. Lock loss restarts the sequence, and
// bounded waits are retried before the block latches a failure.
//
// Optional build macro SATAGTX_LOCK_FILTER_EN: when it is defined, the
// synchronized tile PLL lock and user-clock lock each need C_LOCK_FILTER
// consecutive high cycles before the sequencer trusts them.
`timescale 1ns/1ps

module satagtx_rst_seq #(
  parameter int C_NUM_CHANNELS  = 2,
  parameter int C_GTXRST_CYCLES = 16,
  parameter int C_DCMRST_CYCLES = 8,
  parameter int C_LOCK_TIMEOUT  = 65535,
  parameter int C_MAX_RETRY     = 3,
  parameter int C_LOCK_FILTER   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tile_plllkdet,
  input  logic                      usrclk_locked,
  input  logic [C_NUM_CHANNELS-1:0] resetdone,
  input  logic [C_NUM_CHANNELS-1:0] rx_reset_req,
  output logic                      tile_gtxreset,
  output logic                      usrclk_reset,
  output logic [C_NUM_CHANNELS-1:0] ch_txreset,
  output logic [C_NUM_CHANNELS-1:0] ch_rxreset,
  output logic [C_NUM_CHANNELS-1:0] phy_ready,
  output logic                      seq_fail,
  output logic [2:0]                seq_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GTX_RST  = 3'd1,
    ST_WAIT_PLL = 3'd2,
    ST_DCM_RST  = 3'd3,
    ST_WAIT_DCM = 3'd4,
    ST_CH_RST   = 3'd5,
    ST_READY    = 3'd6,
    ST_FAIL     = 3'd7
  } state_t;

  // The pulse counter only has to reach (longest pulse - 1).
  localparam int PMAX = (C_GTXRST_CYCLES > C_DCMRST_CYCLES) ? C_GTXRST_CYCLES : C_DCMRST_CYCLES;
  localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX);
  localparam int RW   = $clog2(C_DCMRST_CYCLES + 1);
  localparam logic [19:0] C_TMO = 20'(C_LOCK_TIMEOUT);
  localparam logic [3:0]  C_MAXR = 4'(C_MAX_RETRY);

  // Reject parameter values the sequencer was never meant to handle.
  generate
    if (C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > 4 || C_GTXRST_CYCLES < 2 ||
        C_DCMRST_CYCLES < 2 || C_LOCK_TIMEOUT < 1 || C_LOCK_TIMEOUT > 1048575 ||
        C_MAX_RETRY < 1 || C_MAX_RETRY > 15 || C_LOCK_FILTER < 1) begin : g_param_err
      $error("satagtx_rst_seq: parameter out of range");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Input synchronizers. These flops carry no reset on purpose: the lock
  // state of the hardware is not changed by rst, so the sequencer sees the
  // true lock state at once after rst is released.
  // ---------------------------------------------------------------------
  logic [1:0]                plk_sync_reg;
  logic [1:0]                ulk_sync_reg;
  logic [C_NUM_CHANNELS-1:0] rd_meta_reg;
  logic [C_NUM_CHANNELS-1:0] rd_sync_reg;
  logic [1:0]                lock_sync;
  logic [1:0]                lock_filt;
  logic                      plk;
  logic                      ulk;
  logic [C_NUM_CHANNELS-1:0] rd;

  // Two-flop synchronizer for every asynchronous status input.
  always_ff @(posedge clk) begin
    plk_sync_reg <= {plk_sync_reg[0], tile_plllkdet};
    ulk_sync_reg <= {ulk_sync_reg[0], usrclk_locked};
    rd_meta_reg  <= resetdone;
    rd_sync_reg  <= rd_meta_reg;
  end

  assign lock_sync = {ulk_sync_reg[1], plk_sync_reg[1]};

`ifdef SATAGTX_LOCK_FILTER_EN
  localparam int FW = $clog2(C_LOCK_FILTER + 1);

  genvar gi_f;
  generate
    for (gi_f = 0; gi_f < 2; gi_f++) begin : g_filt
      logic [FW-1:0] cnt_reg;

      // Count consecutive high samples and saturate at the filter length.
      always_ff @(posedge clk) begin
        if (!lock_sync[gi_f]) begin
          cnt_reg <= '0;
        end else if (cnt_reg != FW'(C_LOCK_FILTER)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // The lock rises only after a full run of highs. It drops on the
      // first low sample because the sync value gates it directly.
      assign lock_filt[gi_f] = lock_sync[gi_f] & (cnt_reg == FW'(C_LOCK_FILTER));
    end
  endgenerate
`else
  assign lock_filt = lock_sync;
`endif

  assign plk = lock_filt[0];
  assign ulk = lock_filt[1];
  assign rd  = rd_sync_reg;

  // ---------------------------------------------------------------------
  // Sequencer state, counters and registered outputs
  // ---------------------------------------------------------------------
  state_t                    state_reg, state_next;
  logic [PW-1:0]             pulse_cnt_reg, pulse_cnt_next;
  logic [19:0]               tmo_cnt_reg, tmo_cnt_next;
  logic [3:0]                retry_cnt_reg, retry_next;
  logic                      tmo_hit;
  logic                      tmo_fire;

  logic                      tile_gtxreset_reg, tile_gtxreset_next;
  logic                      usrclk_reset_reg, usrclk_reset_next;
  logic [C_NUM_CHANNELS-1:0] ch_txreset_reg, ch_txreset_next;
  logic [C_NUM_CHANNELS-1:0] ch_rxreset_reg, ch_rxreset_next;
  logic [C_NUM_CHANNELS-1:0] phy_ready_reg, phy_ready_next;
  logic                      seq_fail_reg, seq_fail_next;
  logic                      hold_chan;
  logic                      ready_next;

  assign tmo_hit = (tmo_cnt_reg == C_TMO);

  // Next-state logic. A wait that reaches the timeout restarts the
  // sequence (or fails once retries are used up). Lock loss in READY
  // restarts without using a retry.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_cnt_reg;
    tmo_fire   = 1'b0;
    case (state_reg)
      ST_IDLE:     state_next = ST_GTX_RST;
      ST_GTX_RST:  if (pulse_cnt_reg == PW'(C_GTXRST_CYCLES - 1)) state_next = ST_WAIT_PLL;
      ST_WAIT_PLL: begin
        if (plk)          state_next = ST_DCM_RST;
        else if (tmo_hit) tmo_fire   = 1'b1;
      end
      ST_DCM_RST:  if (pulse_cnt_reg == PW'(C_DCMRST_CYCLES - 1)) state_next = ST_WAIT_DCM;
      ST_WAIT_DCM: begin
        if (ulk)          state_next = ST_CH_RST;
        else if (tmo_hit) tmo_fire   = 1'b1;
      end
      ST_CH_RST: begin
        if (&rd)          state_next = ST_READY;
        else if (tmo_hit) tmo_fire   = 1'b1;
      end
      ST_READY: begin
        if (!plk)      state_next = ST_GTX_RST;
        else if (!ulk) state_next = ST_DCM_RST;
      end
      ST_FAIL:     state_next = ST_FAIL;
      default:     state_next = ST_IDLE;
    endcase
    if (tmo_fire) begin
      if (retry_cnt_reg == C_MAXR) begin
        state_next = ST_FAIL;
      end else begin
        state_next = ST_GTX_RST;
        retry_next = retry_cnt_reg + 4'd1;
      end
    end
    if (state_next == ST_READY && state_reg != ST_READY) begin
      retry_next = '0;
    end
  end

  // The pulse and timeout counters restart on every state change. Each one
  // counts only in the states that use it.
  always_comb begin
    pulse_cnt_next = '0;
    tmo_cnt_next   = '0;
    if (state_next == state_reg) begin
      if (state_reg == ST_GTX_RST || state_reg == ST_DCM_RST) begin
        pulse_cnt_next = pulse_cnt_reg + 1'b1;
      end
      if (state_reg == ST_WAIT_PLL || state_reg == ST_WAIT_DCM || state_reg == ST_CH_RST) begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end
  end

  // Output values are decoded from the next state. The registered outputs
  // therefore change in the same cycle as seq_state.
  always_comb begin
    hold_chan          = (state_next != ST_CH_RST) && (state_next != ST_READY);
    ready_next         = (state_next == ST_READY);
    tile_gtxreset_next = (state_next == ST_IDLE) || (state_next == ST_GTX_RST) ||
                         (state_next == ST_FAIL);
    usrclk_reset_next  = (state_next == ST_IDLE) || (state_next == ST_GTX_RST) ||
                         (state_next == ST_WAIT_PLL) || (state_next == ST_DCM_RST) ||
                         (state_next == ST_FAIL);
    ch_txreset_next    = {C_NUM_CHANNELS{hold_chan}};
    seq_fail_next      = (state_next == ST_FAIL);
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
      logic [RW-1:0] rx_cnt_reg, rx_cnt_next;
      logic          rx_accept;

      // Per-channel RX re-reset pulse. The request is honoured only when
      // READY holds across the cycle, so a lock loss in the same cycle wins.
      always_comb begin
        rx_accept   = (state_reg == ST_READY) && (state_next == ST_READY) && rx_reset_req[gi];
        rx_cnt_next = '0;
        if (state_next == ST_READY) begin
          if (rx_accept) begin
            rx_cnt_next = RW'(C_DCMRST_CYCLES);
          end else if (rx_cnt_reg != '0) begin
            rx_cnt_next = rx_cnt_reg - 1'b1;
          end
        end
      end

      // Pulse counter register.
      always_ff @(posedge clk) begin
        if (rst) rx_cnt_reg <= '0;
        else     rx_cnt_reg <= rx_cnt_next;
      end

      assign ch_rxreset_next[gi] = hold_chan | (rx_cnt_next != '0);
      assign phy_ready_next[gi]  = ready_next & rd[gi] & ~ch_rxreset_next[gi];
    end
  endgenerate

  // State, counters and output registers. rst forces the reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      pulse_cnt_reg     <= '0;
      tmo_cnt_reg       <= '0;
      retry_cnt_reg     <= '0;
      tile_gtxreset_reg <= 1'b1;
      usrclk_reset_reg  <= 1'b1;
      ch_txreset_reg    <= '1;
      ch_rxreset_reg    <= '1;
      phy_ready_reg     <= '0;
      seq_fail_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pulse_cnt_reg     <= pulse_cnt_next;
      tmo_cnt_reg       <= tmo_cnt_next;
      retry_cnt_reg     <= retry_next;
      tile_gtxreset_reg <= tile_gtxreset_next;
      usrclk_reset_reg  <= usrclk_reset_next;
      ch_txreset_reg    <= ch_txreset_next;
      ch_rxreset_reg    <= ch_rxreset_next;
      phy_ready_reg     <= phy_ready_next;
      seq_fail_reg      <= seq_fail_next;
    end
  end

  assign tile_gtxreset = tile_gtxreset_reg;
  assign usrclk_reset  = usrclk_reset_reg;
  assign ch_txreset    = ch_txreset_reg;
  assign ch_rxreset    = ch_rxreset_reg;
  assign phy_ready     = phy_ready_reg;
  assign seq_fail      = seq_fail_reg;
  assign seq_state     = state_reg;

endmodule
